// File: rtl/rf_param.sv
// Parametrised register file: 2 comb read ports, 1 write port, clear sweep.
// Ports: clk_i/rst_ni, rd{0,1}_addr_i/data_o, we_i/waddr_i/wdata_i/wready_o,
//        init_busy_o, wr_err_o. Optional write-to-read bypass: RF_BYPASS_EN.
module rf_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] rd0_addr_i,
  output logic [DATA_W-1:0] rd0_data_o,
  input  logic [ADDR_W-1:0] rd1_addr_i,
  output logic [DATA_W-1:0] rd1_data_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              wready_o,
  output logic              init_busy_o,
  output logic              wr_err_o
);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH-1);

  state_t            state;
  logic [ADDR_W:0]   clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              w_acc;
  logic              w_ok;
  logic              w_bad;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];

  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  assign init_busy_o = (state == CLEAR);
  assign wready_o    = (state == READY);

  assign w_acc = we_i && wready_o;
  assign w_ok  = w_acc && in_rng(waddr_i) && !is_zero(waddr_i);
  assign w_bad = w_acc && !in_rng(waddr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= CLEAR;
      clr_ptr  <= '0;
      wr_err_o <= 1'b0;
    end else begin
      wr_err_o <= w_bad;
      case (state)
        CLEAR: begin
          if (clr_ptr == LAST_C) begin
            state <= READY;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        READY: state <= READY;
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it before any read is unmasked.
  always_ff @(posedge clk_i) begin
    if (state == CLEAR) begin
      mem[clr_ptr[ADDR_W-1:0]] <= '0;
    end else if (w_ok) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign ra[0] = rd0_addr_i;
  assign ra[1] = rd1_addr_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = '0;
      if (wready_o && in_rng(ra[p]) && !is_zero(ra[p])) begin
`ifdef RF_BYPASS_EN
        if (w_ok && (ra[p] == waddr_i)) begin
          rd[p] = wdata_i;
        end else begin
          rd[p] = mem[ra[p]];
        end
`else
        rd[p] = mem[ra[p]];
`endif
      end
    end
  end

  assign rd0_data_o = rd[0];
  assign rd1_data_o = rd[1];

endmodule

// File: tb/tb_rf_param.sv
// Directed bench for rf_param: DUT a (DEPTH 32, zero reg) and
// DUT b (DEPTH 20, no zero reg) share all inputs.
module tb_rf_param;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd0_addr, rd1_addr, waddr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1;
  logic        a_wrdy, a_busy, a_err;
  logic        b_wrdy, b_busy, b_err;

  int n_cmp = 0;
  int n_bad = 0;

  rf_param u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .rd0_addr_i(rd0_addr), .rd0_data_o(a_rd0),
    .rd1_addr_i(rd1_addr), .rd1_data_o(a_rd1),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .wready_o(a_wrdy), .init_busy_o(a_busy), .wr_err_o(a_err)
  );

  rf_param #(.DEPTH(20), .ZERO_REG(1'b0)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .rd0_addr_i(rd0_addr), .rd0_data_o(b_rd0),
    .rd1_addr_i(rd1_addr), .rd1_data_o(b_rd1),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .wready_o(b_wrdy), .init_busy_o(b_busy), .wr_err_o(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] ea0, ea1, eb0, eb1;
    logic        eea, eeb;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1, 0, 32'hDEADBEEF, 0, 0, 0, 0,
               BYP ? 32'hDEADBEEF : 0, BYP ? 32'hDEADBEEF : 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    tbl[2] = '{1, 25, 32'hFFFFFFFF, 25, 9,
               BYP ? 32'hFFFFFFFF : 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 25, 9, 32'hFFFFFFFF, 0, 0, 0, 0, 1};
    tbl[4] = '{1, 30, 32'h11, 5, 25,
               32'hAAAA5555, 32'hFFFFFFFF, 32'hAAAA5555, 0, 0, 0};
    tbl[5] = '{1, 31, 32'h22, 30, 31,
               32'h11, BYP ? 32'h22 : 0, 0, 0, 0, 1};
    tbl[6] = '{0, 0, 0, 31, 30, 32'h22, 32'h11, 0, 0, 0, 1};
    tbl[7] = '{0, 0, 0, 9, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
    tbl[8] = '{1, 19, 32'h33, 19, 18,
               BYP ? 32'h33 : 0, 0, BYP ? 32'h33 : 0, 0, 0, 0};
    tbl[9] = '{0, 0, 0, 19, 19, 32'h33, 32'h33, 32'h33, 32'h33, 0, 0};

    rst_n = 1'b0;
    we = 1'b1; waddr = 5'd5; wdata = 32'hAAAA5555;
    rd0_addr = 5'd5; rd1_addr = 5'd5;
    #12;
    chk("rst_busy_a", a_busy, 1);
    chk("rst_wrdy_a", a_wrdy, 0);
    chk("rst_err_a", a_err, 0);
    chk("rst_rd0_a", a_rd0, 0);
    chk("rst_rd1_a", a_rd1, 0);
    chk("rst_busy_b", b_busy, 1);
    chk("rst_wrdy_b", b_wrdy, 0);
    tick();
    rst_n = 1'b1;

    // sweep with a held write request to entry 5
    for (int k = 1; k <= 34; k++) begin
      tick();
      #2;
      chk($sformatf("swp_busy_a_%0d", k), a_busy, k < 32);
      chk($sformatf("swp_wrdy_a_%0d", k), a_wrdy, k >= 32);
      chk($sformatf("swp_busy_b_%0d", k), b_busy, k < 20);
      chk($sformatf("swp_rd0_a_%0d", k), a_rd0,
          (k >= (BYP ? 32 : 33)) ? 32'hAAAA5555 : 0);
    end
    we = 1'b0;
    tick();

    for (int a = 0; a < 32; a++) begin
      rd0_addr = 5'(a);
      rd1_addr = 5'(a);
      #1;
      chk($sformatf("all_a0_%0d", a), a_rd0, a == 5 ? 32'hAAAA5555 : 0);
      chk($sformatf("all_a1_%0d", a), a_rd1, a == 5 ? 32'hAAAA5555 : 0);
      chk($sformatf("all_b0_%0d", a), b_rd0, a == 5 ? 32'hAAAA5555 : 0);
    end

    // table: reads/err checked within the row's cycle, write lands at edge
    tick();
    for (int i = 0; i < 10; i++) begin
      we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd;
      rd0_addr = tbl[i].r0; rd1_addr = tbl[i].r1;
      #2;
      chk($sformatf("tbl%0d_a0", i), a_rd0, tbl[i].ea0);
      chk($sformatf("tbl%0d_a1", i), a_rd1, tbl[i].ea1);
      chk($sformatf("tbl%0d_b0", i), b_rd0, tbl[i].eb0);
      chk($sformatf("tbl%0d_b1", i), b_rd1, tbl[i].eb1);
      chk($sformatf("tbl%0d_erra", i), a_err, tbl[i].eea);
      chk($sformatf("tbl%0d_errb", i), b_err, tbl[i].eeb);
      tick();
    end
    we = 1'b0;

    // bypass corner on entry 7
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    rd0_addr = 5'd7; rd1_addr = 5'd7;
    #2;
    chk("byp_a0", a_rd0, BYP ? 32'h12345678 : 0);
    chk("byp_a1", a_rd1, BYP ? 32'h12345678 : 0);
    chk("byp_b0", b_rd0, BYP ? 32'h12345678 : 0);
    tick();
    we = 1'b0;
    #2;
    chk("byp_nxt_a0", a_rd0, 32'h12345678);
    chk("byp_nxt_a1", a_rd1, 32'h12345678);
    chk("byp_nxt_b1", b_rd1, 32'h12345678);

    // fill every entry with addr * 0x01010101
    for (int a = 0; a < 32; a++) begin
      tick();
      we = 1'b1; waddr = 5'(a); wdata = 32'(a) * 32'h01010101;
      #2;
      chk($sformatf("fill_errb_%0d", a), b_err, a > 20);
    end
    tick();
    we = 1'b0;
    #2;
    chk("fill_errb_last", b_err, 1);
    tick();
    chk("fill_errb_clr", b_err, 0);

    for (int a = 0; a < 32; a++) begin
      rd0_addr = 5'(a);
      rd1_addr = 5'(31 - a);
      #1;
      chk($sformatf("dr_a0_%0d", a), a_rd0, 32'(a) * 32'h01010101);
      chk($sformatf("dr_a1_%0d", a), a_rd1, 32'(31 - a) * 32'h01010101);
      chk($sformatf("dr_b0_%0d", a), b_rd0,
          a < 20 ? 32'(a) * 32'h01010101 : 0);
      chk($sformatf("dr_b1_%0d", a), b_rd1,
          (31 - a) < 20 ? 32'(31 - a) * 32'h01010101 : 0);
    end

    // reset in the middle of the sweep
    rd0_addr = 5'd3; rd1_addr = 5'd3;
    rst_n = 1'b0;
    #1;
    chk("mr_busy_now", a_busy, 1);
    chk("mr_rd0_now", a_rd0, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("mr1_wrdy_%0d", k), a_wrdy, 0);
    end
    rst_n = 1'b0;
    #1;
    chk("mr_busy_a", a_busy, 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("mr_hold_wrdy_%0d", k), a_wrdy, 0);
      chk($sformatf("mr_hold_busy_%0d", k), a_busy, 1);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      tick();
      #2;
      chk($sformatf("mr2_busy_a_%0d", k), a_busy, k < 32);
      chk($sformatf("mr2_wrdy_a_%0d", k), a_wrdy, k >= 32);
      chk($sformatf("mr2_busy_b_%0d", k), b_busy, k < 20);
      chk($sformatf("mr2_rd0_a_%0d", k), a_rd0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
